// File: rtl/net_pkg.sv
// rtl/net_pkg.sv - shared constants and directory-select helper for the L2-to-directory nets
package net_pkg;

    localparam int NET_HASH_DIRECT = 0;
    localparam int NET_HASH_XOR    = 1;

    // Widest payload / select field the helper accepts; callers zero-extend into it.
    localparam int NET_MAX_REQ_W = 512;
    localparam int NET_MAX_DW    = 8;

    // Source index width; a single-bit tag is kept even for degenerate source counts.
    function automatic int net_src_w(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

    // Directory select: direct bank bits, or XOR fold of the bank field with the one above it.
    function automatic int unsigned dr_sel(
        input logic [NET_MAX_REQ_W-1:0] payload,
        input int                       lsb,
        input int                       dw,
        input int                       mode
    );
        logic [NET_MAX_REQ_W-1:0] sh_a;
        logic [NET_MAX_REQ_W-1:0] sh_b;
        logic [NET_MAX_DW-1:0]    ones;
        logic [NET_MAX_DW-1:0]    mask;
        logic [NET_MAX_DW-1:0]    sel;
        ones = '1;
        mask = ~(ones << dw);
        sh_a = payload >> lsb;
        sh_b = payload >> (lsb + dw);
        if (mode == NET_HASH_XOR) begin
            sel = (sh_a[NET_MAX_DW-1:0] ^ sh_b[NET_MAX_DW-1:0]) & mask;
        end else begin
            sel = sh_a[NET_MAX_DW-1:0] & mask;
        end
        return {{(32-NET_MAX_DW){1'b0}}, sel};
    endfunction

endpackage

// File: rtl/net_rr_arb.sv
// rtl/net_rr_arb.sv - round-robin arbiter with registered pointer and one-hot grant
module net_rr_arb #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o
);

    localparam int            PW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx;

    // Search from the pointer, wrapping at N; the winner's successor becomes the next start.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        idx   = ptr_q;
        for (int off = 0; off < N; off++) begin
            if (en_i && (gnt_o == '0) && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                ptr_d      = (idx == LAST) ? '0 : idx + 1'b1;
            end
            idx = (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

    // Pointer register; it only moves when a grant is issued.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/net_l2todr_req_xbar.sv
// rtl/net_l2todr_req_xbar.sv - NUM_SRC x NUM_DR L2-to-directory request crossbar
module net_l2todr_req_xbar
    import net_pkg::*;
#(
    parameter  int NUM_SRC    = 6,
    parameter  int NUM_DR     = 2,
    parameter  int REQ_W      = 64,
    parameter  int DR_SEL_LSB = 6,
    parameter  int HASH_MODE  = 0,
    parameter  int DEPTH      = 2,
    localparam int SRC_W      = net_src_w(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_req_valid,
    output logic [NUM_SRC-1:0]        src_req_retry,
    input  logic [NUM_SRC*REQ_W-1:0]  src_req,
    output logic [NUM_DR-1:0]         dr_req_valid,
    input  logic [NUM_DR-1:0]         dr_req_retry,
    output logic [NUM_DR*REQ_W-1:0]   dr_req,
    output logic [NUM_DR*SRC_W-1:0]   dr_req_src
);

    localparam int             DW      = $clog2(NUM_DR);
    localparam int             QW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [QW-1:0]  QLAST   = QW'(DEPTH - 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic [NET_MAX_REQ_W-1:0]         pay_ext [NUM_SRC];
    int unsigned                      sel     [NUM_SRC];
    logic [NUM_DR-1:0][NUM_SRC-1:0]   cand;
    logic [NUM_DR-1:0][NUM_SRC-1:0]   gnt;
    logic [NUM_DR-1:0]                space;
    logic [NUM_SRC-1:0]               grant_any;

    logic [NUM_DR-1:0]                push;
    logic [NUM_DR-1:0]                pop;
    logic [REQ_W-1:0]                 push_pay [NUM_DR];
    logic [SRC_W-1:0]                 push_src [NUM_DR];

    logic [REQ_W-1:0]                 mem_q  [NUM_DR][DEPTH];
    logic [SRC_W-1:0]                 msrc_q [NUM_DR][DEPTH];
    logic [QW-1:0]                    wr_q   [NUM_DR];
    logic [QW-1:0]                    rd_q   [NUM_DR];
    logic [CW-1:0]                    cnt_q  [NUM_DR];

    // Steer every source to one directory and build each directory's candidate set.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            pay_ext[i]            = '0;
            pay_ext[i][REQ_W-1:0] = src_req[i*REQ_W +: REQ_W];
            sel[i]                = dr_sel(pay_ext[i], DR_SEL_LSB, DW, HASH_MODE);
        end
        for (int d = 0; d < NUM_DR; d++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cand[d][i] = src_req_valid[i] && (sel[i] == d);
            end
        end
    end

    // Space uses the registered count only, so directory retry never reaches source retry.
    always_comb begin
        for (int d = 0; d < NUM_DR; d++) begin
            space[d] = reset && (cnt_q[d] < DEPTH_C);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DR; g++) begin : g_arb
            net_rr_arb #(.N(NUM_SRC)) u_arb (
                .clk    (clk),
                .resetn (reset),
                .req_i  (cand[g]),
                .en_i   (space[g]),
                .gnt_o  (gnt[g])
            );
        end
    endgenerate

    // Source retry: a valid source that no directory granted this cycle.
    always_comb begin
        grant_any = '0;
        for (int d = 0; d < NUM_DR; d++) begin
            grant_any = grant_any | gnt[d];
        end
        src_req_retry = src_req_valid & ~grant_any;
    end

    // Push data is the granted source's payload tagged with its index; pop on accepted output.
    always_comb begin
        for (int d = 0; d < NUM_DR; d++) begin
            push[d]     = |gnt[d];
            pop[d]      = (cnt_q[d] != '0) && !dr_req_retry[d];
            push_pay[d] = '0;
            push_src[d] = '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (gnt[d][i]) begin
                    push_pay[d] = src_req[i*REQ_W +: REQ_W];
                    push_src[d] = SRC_W'(i);
                end
            end
        end
    end

    // Queue storage; contents are don't-care while the matching count says empty.
    always_ff @(posedge clk) begin
        for (int d = 0; d < NUM_DR; d++) begin
            if (push[d]) begin
                mem_q[d][wr_q[d]]  <= push_pay[d];
                msrc_q[d][wr_q[d]] <= push_src[d];
            end
        end
    end

    // Queue pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        for (int d = 0; d < NUM_DR; d++) begin
            if (!reset) begin
                wr_q[d]  <= '0;
                rd_q[d]  <= '0;
                cnt_q[d] <= '0;
            end else begin
                if (push[d]) begin
                    wr_q[d] <= (wr_q[d] == QLAST) ? '0 : wr_q[d] + 1'b1;
                end
                if (pop[d]) begin
                    rd_q[d] <= (rd_q[d] == QLAST) ? '0 : rd_q[d] + 1'b1;
                end
                if (push[d] && !pop[d]) begin
                    cnt_q[d] <= cnt_q[d] + 1'b1;
                end else if (!push[d] && pop[d]) begin
                    cnt_q[d] <= cnt_q[d] - 1'b1;
                end
            end
        end
    end

    // Present the queue head; outputs are forced to zero whenever the queue is empty.
    always_comb begin
        for (int d = 0; d < NUM_DR; d++) begin
            dr_req_valid[d] = (cnt_q[d] != '0);
            if (dr_req_valid[d]) begin
                dr_req[d*REQ_W +: REQ_W]     = mem_q[d][rd_q[d]];
                dr_req_src[d*SRC_W +: SRC_W] = msrc_q[d][rd_q[d]];
            end else begin
                dr_req[d*REQ_W +: REQ_W]     = '0;
                dr_req_src[d*SRC_W +: SRC_W] = '0;
            end
        end
    end

endmodule

// File: doc/net_l2todr_req_xbar.md
Name: net_l2todr_req_xbar

Overview:
- Parametrised NUM_SRC-to-NUM_DR request crossbar; successor to the fixed 2-core/2-directory net.
- Carries L2-to-directory request traffic (L2I plus every L2D pipe of every core) to any directory.
- Steers each request by address bank bits (selectable hash) and arbitrates per directory with round-robin.
- Buffers each directory output in a DEPTH-entry queue and tags each request with its source index for the return path.

Parameters:
NUM_SRC, 6, number of L2 request sources (any value >=2)
NUM_DR, 2, number of directories (power of 2, >=2)
REQ_W, 64, request payload width (packed I_l2todr_req_type)
DR_SEL_LSB, 6, payload bit where directory-select bits start (line offset above)
HASH_MODE, 0, 0 = direct bank bits; 1 = XOR fold of two adjacent bank fields
DEPTH, 2, per-directory output queue depth (>=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
src_req_valid  in  NUM_SRC  per-source request valid
src_req_retry  out  NUM_SRC  per-source retry; transfer = valid & ~retry
src_req  in  NUM_SRC*REQ_W  per-source payload, source i at [i*REQ_W +: REQ_W]
dr_req_valid  out  NUM_DR  per-directory request valid
dr_req_retry  in  NUM_DR  per-directory retry
dr_req  out  NUM_DR*REQ_W  per-directory payload
dr_req_src  out  NUM_DR*SRC_W  source index of the head request; SRC_W = max(1,clog2(NUM_SRC))

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low. Reset acts when reset==0 at the clk rising edge.
- Reset state:
  - all queues empty
  - dr_req_valid = 0
  - dr_req and dr_req_src = 0
  - all round-robin pointers = 0
  - while reset is low, src_req_retry = src_req_valid (no grants).
- Directory select, DW = clog2(NUM_DR):
  - HASH_MODE 0: sel = payload[DR_SEL_LSB +: DW].
  - HASH_MODE 1: sel = payload[DR_SEL_LSB +: DW] ^ payload[DR_SEL_LSB+DW +: DW].
- Arbitration, per directory d:
  - Candidates are valid sources with sel == d.
  - Grant only if queue count < DEPTH, using the registered count; a same-cycle pop does not free space (keeps dr_req_retry off the src_req_retry path).
  - Round-robin: search starts at ptr[d] and wraps modulo NUM_SRC. On a grant to source k, ptr[d] <= (k+1) mod NUM_SRC. No grant leaves ptr unchanged.
- Source retry: src_req_retry[i] = src_req_valid[i] & ~grant[i], where grant[i] is the OR over directories. Purely combinational from src_req_valid, src_req and registered state. Retry is 0 when valid is 0.
- A source targets exactly one directory per cycle, so at most one grant per source and one push per directory per cycle.
- Queue per directory:
  - FIFO of {src index, payload}.
  - Push on grant; pop when dr_req_valid & ~dr_req_retry.
  - Simultaneous push and pop: count unchanged, both occur.
  - Full (count==DEPTH): no grant. Empty: dr_req_valid = 0.
  - Pointers wrap modulo DEPTH.
- Timing:
  - Latency: request accepted at cycle N appears at dr_req_valid at N+1.
  - Throughput: 1 req/cycle/directory sustained with DEPTH>=2 and no directory retry.
- Ordering: FIFO order per directory is preserved. Requests from one source to one directory stay in order. No ordering is guaranteed across directories.
- Stability: dr_req and dr_req_src are held stable while dr_req_valid & dr_req_retry.
- Reset mid-operation: queued entries are discarded; outputs return to reset values on the next edge.

Decomposition:
- Shared package net_pkg:
  - NET_HASH_DIRECT / NET_HASH_XOR constants
  - dr_sel function (payload, lsb, mode)
  - SRC_W derivation
  - I_l2todr_req_type stays in its existing package.
- Sub-module net_rr_arb: NUM_SRC-wide round-robin arbiter with registered pointer and one-hot grant, instantiated NUM_DR times.
- Queues are inline in the top level.

Test Plan:
- Single route: NUM_SRC=6, NUM_DR=2, HASH_MODE 0. Src 3 sends payload with bit6=1 at cycle 10, dr_req_retry=0 → dr_req_valid[1]=1 at cycle 11 with matching payload, dr_req_src[1]=3, src_req_retry[3]=0 at cycle 10.
- Fairness: srcs 0, 2, 5 hold valid to dr0 continuously, no retry → grants 0,2,5,0,2,5; each source receives exactly 4 of 12 grants.
- Backpressure: dr_req_retry[0]=1, src 1 streams to dr0 → 2 accepts, then src_req_retry[1]=1. Release retry for one cycle → one pop, next cycle one accept, count stays 2. Payload order is preserved.
- Hash: HASH_MODE 1, payload bits[7:6]=2'b11 → sel = 1^1 = 0, routed to dr0. Bits[7:6]=2'b01 → dr1.
- Parallel plus reset: src 0→dr0 and src 1→dr1 in the same cycle → both granted, both outputs valid next cycle. Then reset=0 for one cycle with queues full → dr_req_valid=0, ptr=0, and src_req_retry = valid during reset.
